// File: rtl/jtag_soft_tap.sv
// jtag_soft_tap: soft IEEE 1149.1 TAP controller clocked by TCK. It replaces a
// BSCANE2-style primitive in front of a user-register stage.
//
// Build option: define SOFT_TAP_IDCODE_EN to include the 32-bit IDCODE register.
// In that build the reset opcode is IDCODE_IR. Without it the reset opcode is
// all-ones (BYPASS).
//
// Ports:
//   TCK       test clock; all state on posedge, TDO register on negedge
//   RESET     synchronous active-high reset, sampled on posedge TCK
//   TMS, TDI  JTAG pins
//   DR_TDO    serial output of the downstream user register
//   TDO       test data out (registered on negedge)
//   TDI_O     combinational copy of TDI
//   TAP_RESET / RUNTEST / CAPTURE / SHIFT / UPDATE
//             state indicators (Test-Logic-Reset, Run-Test/Idle, Capture-DR,
//             Shift-DR, Update-DR)
//   SEL       active IR equals USER_IR
module jtag_soft_tap #(
  parameter int unsigned       IR_LEN    = 6,
  parameter logic [IR_LEN-1:0] USER_IR   = 6'h02,
  parameter logic [IR_LEN-1:0] IDCODE_IR = 6'h09,
  parameter logic [31:0]       IDCODE    = 32'h0362D093
) (
  input  logic TCK,
  input  logic RESET,
  input  logic TMS,
  input  logic TDI,
  input  logic DR_TDO,
  output logic TDO,
  output logic TDI_O,
  output logic TAP_RESET,
  output logic RUNTEST,
  output logic SEL,
  output logic CAPTURE,
  output logic SHIFT,
  output logic UPDATE
);

  localparam logic [3:0] StTlr   = 4'd0;
  localparam logic [3:0] StRti   = 4'd1;
  localparam logic [3:0] StSelDr = 4'd2;
  localparam logic [3:0] StCapDr = 4'd3;
  localparam logic [3:0] StShDr  = 4'd4;
  localparam logic [3:0] StEx1Dr = 4'd5;
  localparam logic [3:0] StPauDr = 4'd6;
  localparam logic [3:0] StEx2Dr = 4'd7;
  localparam logic [3:0] StUpdDr = 4'd8;
  localparam logic [3:0] StSelIr = 4'd9;
  localparam logic [3:0] StCapIr = 4'd10;
  localparam logic [3:0] StShIr  = 4'd11;
  localparam logic [3:0] StEx1Ir = 4'd12;
  localparam logic [3:0] StPauIr = 4'd13;
  localparam logic [3:0] StEx2Ir = 4'd14;
  localparam logic [3:0] StUpdIr = 4'd15;

`ifdef SOFT_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] RstIr = IDCODE_IR;
`else
  localparam logic [IR_LEN-1:0] RstIr = {IR_LEN{1'b1}};
`endif

  logic [3:0]        state_q, state_d;
  logic [IR_LEN-1:0] ir_q;
  logic [IR_LEN-1:0] ir_sr_q;
  logic              bypass_q;
  logic              tdo_q;
  logic              sel_user;
  logic              sel_idcode;
  logic              dr_bit;

  always_comb begin
    state_d = StTlr;
    unique case (state_q)
      StTlr:   state_d = TMS ? StTlr   : StRti;
      StRti:   state_d = TMS ? StSelDr : StRti;
      StSelDr: state_d = TMS ? StSelIr : StCapDr;
      StCapDr: state_d = TMS ? StEx1Dr : StShDr;
      StShDr:  state_d = TMS ? StEx1Dr : StShDr;
      StEx1Dr: state_d = TMS ? StUpdDr : StPauDr;
      StPauDr: state_d = TMS ? StEx2Dr : StPauDr;
      StEx2Dr: state_d = TMS ? StUpdDr : StShDr;
      StUpdDr: state_d = TMS ? StSelDr : StRti;
      StSelIr: state_d = TMS ? StTlr   : StCapIr;
      StCapIr: state_d = TMS ? StEx1Ir : StShIr;
      StShIr:  state_d = TMS ? StEx1Ir : StShIr;
      StEx1Ir: state_d = TMS ? StUpdIr : StPauIr;
      StPauIr: state_d = TMS ? StEx2Ir : StPauIr;
      StEx2Ir: state_d = TMS ? StUpdIr : StShIr;
      StUpdIr: state_d = TMS ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  assign sel_user = (ir_q == USER_IR);

  // State, IR path and BYPASS register. The active IR is loaded on the edge
  // that enters UpdIR so SEL moves exactly with that edge.
  always_ff @(posedge TCK) begin
    if (RESET) begin
      state_q  <= StTlr;
      ir_q     <= RstIr;
      ir_sr_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StCapIr: ir_sr_q <= {{(IR_LEN-2){1'b0}}, 2'b01};
        StShIr:  ir_sr_q <= {TDI, ir_sr_q[IR_LEN-1:1]};
        default: ;
      endcase
      if (state_d == StUpdIr) begin
        ir_q <= ir_sr_q;
      end else if (state_d == StTlr) begin
        ir_q <= RstIr;
      end
      if (!sel_user && !sel_idcode) begin
        if (state_q == StCapDr) begin
          bypass_q <= 1'b0;
        end else if (state_q == StShDr) begin
          bypass_q <= TDI;
        end
      end
    end
  end

`ifdef SOFT_TAP_IDCODE_EN
  logic [31:0] idcode_sr_q;

  assign sel_idcode = !sel_user && (ir_q == IDCODE_IR);

  always_ff @(posedge TCK) begin
    if (RESET) begin
      idcode_sr_q <= '0;
    end else if (sel_idcode) begin
      if (state_q == StCapDr) begin
        idcode_sr_q <= IDCODE;
      end else if (state_q == StShDr) begin
        idcode_sr_q <= {TDI, idcode_sr_q[31:1]};
      end
    end
  end

  assign dr_bit = sel_user ? DR_TDO : (sel_idcode ? idcode_sr_q[0] : bypass_q);
`else
  // IDCODE_IR falls through to BYPASS; the parameters are kept for port-map
  // compatibility with the IDCODE build.
  logic unused_cfg;
  assign unused_cfg = ^{IDCODE, IDCODE_IR};
  assign sel_idcode = 1'b0;
  assign dr_bit     = sel_user ? DR_TDO : bypass_q;
`endif

  always_ff @(negedge TCK) begin
    if (state_q == StShIr) begin
      tdo_q <= ir_sr_q[0];
    end else if (state_q == StShDr) begin
      tdo_q <= dr_bit;
    end else begin
      tdo_q <= 1'b0;
    end
  end

  assign TDO       = tdo_q;
  assign TDI_O     = TDI;
  assign TAP_RESET = (state_q == StTlr);
  assign RUNTEST   = (state_q == StRti);
  assign CAPTURE   = (state_q == StCapDr);
  assign SHIFT     = (state_q == StShDr);
  assign UPDATE    = (state_q == StUpdDr);
  assign SEL       = sel_user;

endmodule

// File: tb/tb_jtag_soft_tap.sv
module tb_jtag_soft_tap;

  localparam int unsigned IR_LEN    = 6;
  localparam int unsigned USER_OP   = 'h02;
  localparam int unsigned IDCODE_OP = 'h09;
  localparam bit [31:0]   IDCODE_V  = 32'h0362D093;
`ifdef SOFT_TAP_IDCODE_EN
  localparam int unsigned RST_OP    = IDCODE_OP;
`else
  localparam int unsigned RST_OP    = (1 << IR_LEN) - 1;
`endif

  logic TCK = 1'b0;
  logic RESET = 1'b0, TMS = 1'b1, TDI = 1'b0, DR_TDO = 1'b0;
  logic TDO, TDI_O, TAP_RESET, RUNTEST, SEL, CAPTURE, SHIFT, UPDATE;

  jtag_soft_tap dut (
    .TCK       (TCK),
    .RESET     (RESET),
    .TMS       (TMS),
    .TDI       (TDI),
    .DR_TDO    (DR_TDO),
    .TDO       (TDO),
    .TDI_O     (TDI_O),
    .TAP_RESET (TAP_RESET),
    .RUNTEST   (RUNTEST),
    .SEL       (SEL),
    .CAPTURE   (CAPTURE),
    .SHIFT     (SHIFT),
    .UPDATE    (UPDATE)
  );

  always #5 TCK = ~TCK;

  int n_checks = 0;
  int n_fail   = 0;
  int shift_edges = 0;

  // Reference model: TAP graph by state name, registers as plain integers.
  string       nx0[string];
  string       nx1[string];
  string       m_state = "TLR";
  int unsigned m_ir    = RST_OP;
  int unsigned m_irsr  = 0;
  bit [31:0]   m_id    = 0;
  bit          m_byp   = 0;
  logic        m_tdo   = 1'b0;

  task automatic add_tr(input string s, input string on0, input string on1);
    nx0[s] = on0;
    nx1[s] = on1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_user();
    return m_ir == USER_OP;
  endfunction

  function automatic bit m_idsel();
`ifdef SOFT_TAP_IDCODE_EN
    return !m_user() && m_ir == IDCODE_OP;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_posedge(input logic tms, input logic tdi, input logic rst);
    if (rst) begin
      m_state = "TLR";
      m_ir    = RST_OP;
      m_irsr  = 0;
      m_id    = 0;
      m_byp   = 0;
      return;
    end
    if (m_state == "CapIR") m_irsr = 1;
    else if (m_state == "ShIR") m_irsr = (m_irsr >> 1) + (tdi ? (1 << (IR_LEN - 1)) : 0);
    else if (!m_user() && m_idsel()) begin
      if (m_state == "CapDR") m_id = IDCODE_V;
      else if (m_state == "ShDR") m_id = (m_id >> 1) + (tdi ? 32'h8000_0000 : 32'h0);
    end else if (!m_user()) begin
      if (m_state == "CapDR") m_byp = 0;
      else if (m_state == "ShDR") m_byp = tdi;
    end
    m_state = tms ? nx1[m_state] : nx0[m_state];
    if (m_state == "UpdIR") m_ir = m_irsr;
    else if (m_state == "TLR") m_ir = RST_OP;
  endtask

  task automatic model_negedge(input logic drt);
    if (m_state == "ShIR") m_tdo = m_irsr[0];
    else if (m_state == "ShDR") m_tdo = m_user() ? drt : (m_idsel() ? m_id[0] : m_byp);
    else m_tdo = 1'b0;
  endtask

  // One TCK cycle: drive, posedge, check indicators, negedge, check TDO.
  task automatic tick(input logic tms, input logic tdi, input logic rst, input logic drt);
    logic [5:0] exp_ind;
    TMS = tms; TDI = tdi; RESET = rst; DR_TDO = drt;
    #1;
    check("tdi_o", TDI_O, tdi);
    if (SHIFT) shift_edges++;
    @(posedge TCK);
    model_posedge(tms, tdi, rst);
    #1;
    exp_ind = {m_state == "TLR", m_state == "RTI", m_state == "CapDR",
               m_state == "ShDR", m_state == "UpdDR", m_user()};
    check("indicators", {TAP_RESET, RUNTEST, CAPTURE, SHIFT, UPDATE, SEL}, exp_ind);
    @(negedge TCK);
    model_negedge(drt);
    #1;
    check("tdo", TDO, m_tdo);
    RESET = 1'b0;
  endtask

  // From RTI: load op into IR, return to RTI; captured IR bits out.
  task automatic shift_ir(input int unsigned op, output bit [63:0] out);
    out = 0;
    tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    for (int i = 0; i < IR_LEN; i++) begin
      out[i] = TDO;
      tick(i == IR_LEN - 1, op[i], 0, 0);
    end
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
  endtask

  // From RTI: n-bit DR scan, return to RTI; TDO bits out, DR_TDO randomized.
  task automatic shift_dr(input int n, input bit [63:0] data, output bit [63:0] out);
    out = 0;
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    shift_edges = 0;
    for (int i = 0; i < n; i++) begin
      out[i] = TDO;
      tick(i == n - 1, data[i], 0, 1'($urandom_range(0, 1)));
    end
    check("shift_edges", shift_edges, n);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit [63:0] out;
    add_tr("TLR", "RTI", "TLR");      add_tr("RTI", "RTI", "SelDR");
    add_tr("SelDR", "CapDR", "SelIR"); add_tr("CapDR", "ShDR", "Ex1DR");
    add_tr("ShDR", "ShDR", "Ex1DR");   add_tr("Ex1DR", "PauDR", "UpdDR");
    add_tr("PauDR", "PauDR", "Ex2DR"); add_tr("Ex2DR", "ShDR", "UpdDR");
    add_tr("UpdDR", "RTI", "SelDR");   add_tr("SelIR", "CapIR", "TLR");
    add_tr("CapIR", "ShIR", "Ex1IR");  add_tr("ShIR", "ShIR", "Ex1IR");
    add_tr("Ex1IR", "PauIR", "UpdIR"); add_tr("PauIR", "PauIR", "Ex2IR");
    add_tr("Ex2IR", "ShIR", "UpdIR");  add_tr("UpdIR", "RTI", "SelDR");

    // Reset state.
    tick(0, 0, 1, 0);
    tick(1, 0, 1, 0);
    check("rst_tap_reset", TAP_RESET, 1'b1);
    check("rst_runtest", RUNTEST, 1'b0);
    check("rst_sel", SEL, 1'b0);
    check("rst_tdo", TDO, 1'b0);

    // Random walk with occasional reset, then five TMS=1 edges.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 2) != 0 ? $urandom_range(0, 1) : 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 5; i++) tick(1, 1'($urandom_range(0, 1)), 0, 0);
    check("tlr5_tap_reset", TAP_RESET, 1'b1);
    check("tlr5_sel", SEL, 1'b0);
    check("tlr5_runtest", RUNTEST, 1'b0);

    // Default DR after reset.
    tick(0, 0, 0, 0);
`ifdef SOFT_TAP_IDCODE_EN
    shift_dr(32, 64'h0, out);
    check("idcode_stream", out[31:0], IDCODE_V);
`else
    shift_dr(2, 64'h3, out);
    check("bypass_2bit", out[1:0], 2'b10);
`endif

    // USER register.
    shift_ir(USER_OP, out);
    check("ir_capture_user", out[5:0], 6'b000001);
    check("user_sel", SEL, 1'b1);
    shift_dr(32, {$urandom, $urandom}, out);

    // BYPASS with 8'hA5.
    shift_ir('h3F, out);
    check("ir_capture_byp", out[5:0], 6'b000001);
    check("byp_sel", SEL, 1'b0);
    shift_dr(9, 64'h0A5, out);
    check("bypass_a5", out[8:0], {8'hA5, 1'b0});

    // RESET during the 16th bit of a USER scan.
    shift_ir(USER_OP, out);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick(0, 1'($urandom_range(0, 1)), 0, 1'b1);
    tick(0, 1'b1, 1'b1, 1'b1);
    check("midrst_tap_reset", TAP_RESET, 1'b1);
    check("midrst_sel", SEL, 1'b0);
    check("midrst_tdo", TDO, 1'b0);

    // Random tail with random IR loads.
    tick(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      shift_ir(k[0] ? USER_OP : $urandom_range(0, 63), out);
      shift_dr($urandom_range(1, 40), {$urandom, $urandom}, out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
